// File: rtl/lut_sweep_pkg.sv
// Shared types and helpers for the LUT-cascade exhaustive sweeper.
package lut_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

  localparam int unsigned IN_W_DEF = 7;
  localparam int unsigned N        = 1 << IN_W_DEF;

  // Width of the settle counter; never narrower than one bit.
  function automatic int unsigned settle_w(input int unsigned settle);
    return (settle == 0) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/lut_sweep_ones_ctr.sv
// Single-bit ones counter: clear has priority, increments when en and d are high.
module lut_sweep_ones_ctr #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             d,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && d) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lut_cascade_sweeper.sv
// Drives every input vector onto a combinational LUT cascade, counts ones per
// output bit after a settle interval, and compares the totals with EXP_ONES.
module lut_cascade_sweeper
  import lut_sweep_pkg::*;
#(
  parameter int unsigned IN_W   = 7,
  parameter int unsigned OUT_W  = 2,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = IN_W + 1,
  parameter logic [OUT_W*CNT_W-1:0] EXP_ONES = {8'd44, 8'd56}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [IN_W-1:0]        dut_i,
  input  logic [OUT_W-1:0]       dut_o,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [OUT_W*CNT_W-1:0] ones_cnt,
  output logic [IN_W-1:0]        vec_idx
);

  localparam int unsigned SW = settle_w(SETTLE);
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam sweep_state_t FIRST_ST = (SETTLE == 0) ? SAMPLE : DRIVE;

  sweep_state_t  st;
  logic [SW-1:0] settle_cnt;
  logic          accept;
  logic          sample_en;

  assign accept    = start && (st == IDLE || st == DONE);
  assign sample_en = (st == SAMPLE);

  for (genvar k = 0; k < OUT_W; k++) begin : g_ctr
    lut_sweep_ones_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .clr   (accept),
      .en    (sample_en),
      .d     (dut_o[k]),
      .count (ones_cnt[k*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      dut_i      <= '0;
      vec_idx    <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      case (st)
        IDLE, DONE: begin
          // done/pass follow entry into DONE by one cycle so the compare
          // sees the counts after the final sample has landed.
          if (st == DONE) begin
            done <= 1'b1;
            pass <= (ones_cnt == EXP_ONES);
          end
          if (start) begin
            st         <= FIRST_ST;
            vec_idx    <= '0;
            dut_i      <= '0;
            settle_cnt <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
          end
        end
        DRIVE: begin
          settle_cnt <= settle_cnt + SW'(1);
          if (settle_cnt == SETTLE_LAST) st <= SAMPLE;
        end
        SAMPLE: begin
          if (vec_idx == '1) begin
            st   <= DONE;
            busy <= 1'b0;
          end else begin
            vec_idx    <= vec_idx + IN_W'(1);
            dut_i      <= dut_i + IN_W'(1);
            settle_cnt <= '0;
            st         <= FIRST_ST;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_cascade_sweeper.sv
// Bench for lut_cascade_sweeper: SETTLE=1 and SETTLE=0 instances share a
// behavioural cascade model; sweep results are scoreboarded at done.
module tb_lut_cascade_sweeper;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stuck = 1'b0;
  logic        start1 = 1'b0, start0 = 1'b0;
  logic [6:0]  dut_i1, dut_i0, vec_idx1, vec_idx0;
  logic [1:0]  dut_o1, dut_o0;
  logic        busy1, busy0, done1, done0, pass1, pass0;
  logic [15:0] cnt1, cnt0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [1:0] model(input logic [6:0] i);
    logic       o0;
    logic [3:0] k;
    o0 = i[3:0] inside {4'd0, 4'd8, 4'd9, 4'd10, 4'd12, 4'd14, 4'd15};
    k  = {o0, i[6:4]};
    return {k inside {4'b0000, 4'b1001, 4'b1010, 4'b1100, 4'b1110, 4'b1111}, o0};
  endfunction

  assign dut_o1 = model(dut_i1) & {~stuck, 1'b1};
  assign dut_o0 = model(dut_i0) & {~stuck, 1'b1};

  lut_cascade_sweeper #(.IN_W(7), .OUT_W(2), .SETTLE(1), .CNT_W(8),
                        .EXP_ONES(16'h2C38)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .dut_i(dut_i1), .dut_o(dut_o1),
    .busy(busy1), .done(done1), .pass(pass1), .ones_cnt(cnt1), .vec_idx(vec_idx1));

  lut_cascade_sweeper #(.IN_W(7), .OUT_W(2), .SETTLE(0), .CNT_W(8),
                        .EXP_ONES(16'h2C38)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .dut_i(dut_i0), .dut_o(dut_o0),
    .busy(busy0), .done(done0), .pass(pass0), .ones_cnt(cnt0), .vec_idx(vec_idx0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int          lat;
    logic [15:0] cnt;
    bit          p;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    bit          sel0;
    bit          stk;
    int          lat;
    logic [15:0] cnt;
    bit          p;
  } vec_t;

  // Drive one start pulse on the selected instance, then wait for done and
  // compare against the scoreboard entry pushed at stimulus time.
  task automatic run_sweep(input bit sel0, input bit stk, input int lat,
                           input logic [15:0] cnt, input bit p);
    exp_t e;
    int   n;
    int   seq_err;
    sbq.push_back('{lat, cnt, p});
    stuck = stk;
    @(negedge clk);
    if (sel0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    check("accept_done", sel0 ? done0 : done1, 0);
    check("accept_busy", sel0 ? busy0 : busy1, 1);
    check("accept_dut_i", sel0 ? dut_i0 : dut_i1, 0);
    n = 0;
    seq_err = 0;
    while (!(sel0 ? done0 : done1) && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (sel0 && n <= 127 && dut_i0 != 7'(n)) seq_err++;
    end
    e = sbq.pop_front();
    check("latency", n, e.lat);
    check("ones_cnt", sel0 ? cnt0 : cnt1, e.cnt);
    check("pass", sel0 ? pass0 : pass1, e.p);
    check("final_dut_i", sel0 ? dut_i0 : dut_i1, 127);
    check("final_busy", sel0 ? busy0 : busy1, 0);
    if (sel0) check("s0_sequence_errors", seq_err, 0);
  endtask

  vec_t tbl[4];

  initial begin
    int idle_err;
    int n;
    tbl[0] = '{0, 0, 257, {8'd44, 8'd56}, 1};
    tbl[1] = '{1, 0, 129, {8'd44, 8'd56}, 1};
    tbl[2] = '{0, 1, 257, {8'd0,  8'd56}, 0};
    tbl[3] = '{1, 1, 129, {8'd0,  8'd56}, 0};

    #2 rst = 1'b1;
    #1;
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_pass", pass1, 0);
    check("rst_dut_i", dut_i1, 0);
    check("rst_cnt", cnt1, 0);
    check("rst_cnt_s0", cnt0, 0);
    @(negedge clk); rst = 1'b0;

    idle_err = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (busy1 || done1 || pass1 || dut_i1 != 0 || busy0 || done0 || dut_i0 != 0)
        idle_err++;
    end
    check("idle_errors", idle_err, 0);

    for (int i = 0; i < 4; i++)
      run_sweep(tbl[i].sel0, tbl[i].stk, tbl[i].lat, tbl[i].cnt, tbl[i].p);

    // start held high through most of the sweep must not restart it
    stuck = 1'b0;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (n < 250) begin
      @(posedge clk); #1;
      n++;
      if (n == 200) check("hold_vec_idx", vec_idx1, 100);
    end
    start1 = 1'b0;
    while (!done1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_latency", n, 257);
    check("hold_cnt", cnt1, 16'h2C38);
    check("hold_pass", pass1, 1);
    run_sweep(0, 0, 257, {8'd44, 8'd56}, 1);

    // asynchronous reset mid-SAMPLE at vector 60
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 1; i <= 121; i++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_vec_idx", vec_idx1, 60);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_dut_i", dut_i1, 0);
    check("mid_rst_vec_idx", vec_idx1, 0);
    check("mid_rst_cnt", cnt1, 0);
    check("mid_rst_done_pass", {done1, pass1}, 0);
    @(negedge clk); rst = 1'b0;
    run_sweep(0, 0, 257, {8'd44, 8'd56}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
